// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_receiver
// Purpose  : Recovers raster position from hsync/vsync, qualifies the stream
//            with a SEARCH/MEASURE/LOCKED machine and flags timing faults.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_receiver #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_TOTAL     = 800,
    parameter int V_VISIBLE   = 400,
    parameter int V_FRONT     = 12,
    parameter int V_TOTAL     = 449,
    parameter int HS_ACTIVE   = 0,
    parameter int VS_ACTIVE   = 1,
    parameter int H_ALIGN     = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] h_pos,
    output logic [8:0] v_pos,
    output logic       de,
    output logic       locked,
    output logic       frame_start,
    output logic       line_err
);

    localparam logic [1:0]  c_ST_SEARCH  = 2'd0;
    localparam logic [1:0]  c_ST_MEASURE = 2'd1;
    localparam logic [1:0]  c_ST_LOCKED  = 2'd2;

    localparam logic        c_HS_ON      = (HS_ACTIVE != 0);
    localparam logic        c_VS_ON      = (VS_ACTIVE != 0);
    localparam logic [9:0]  c_H_LOAD     = 10'((H_VISIBLE + H_FRONT + H_ALIGN) % H_TOTAL);
    localparam logic [9:0]  c_H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [8:0]  c_V_LOAD     = 9'((V_VISIBLE + V_FRONT) % V_TOTAL);
    localparam logic [8:0]  c_V_LAST     = 9'(V_TOTAL - 1);
    // Counter clears on the edge itself, so a correct line reads H_TOTAL-1.
    localparam logic [10:0] c_PERIOD_OK  = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_PERIOD_MAX = 11'h7FF;
    localparam logic [9:0]  c_LINES_OK   = 10'(V_TOTAL);
    localparam logic [9:0]  c_LINES_MAX  = 10'h3FF;
    localparam int          c_GOOD_W     = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;
    localparam logic [c_GOOD_W-1:0] c_GOOD_LOCK = c_GOOD_W'(LOCK_FRAMES);

    logic                r_hs, r_hs_d, r_vs, r_vs_d;
    logic [9:0]          r_h_pos;
    logic [8:0]          r_v_pos;
    logic [10:0]         r_period;
    logic                r_sat_seen;
    logic [9:0]          r_lines;
    logic                r_skip;
    logic [c_GOOD_W-1:0] r_good;
    logic [1:0]          r_state;
    logic                r_line_err;

    logic                w_hs_edge, w_vs_edge, w_h_wrap;
    logic                w_period_bad, w_sat_bad, w_frame_bad, w_err;
    logic [c_GOOD_W-1:0] w_good_next;

    assign w_hs_edge    = (r_hs == c_HS_ON) && (r_hs_d != c_HS_ON);
    assign w_vs_edge    = (r_vs == c_VS_ON) && (r_vs_d != c_VS_ON);
    assign w_h_wrap     = !w_hs_edge && (r_h_pos == c_H_LAST);
    assign w_period_bad = w_hs_edge && !r_skip && (r_period != c_PERIOD_OK);
    assign w_sat_bad    = !w_hs_edge && (r_period == c_PERIOD_MAX) && !r_sat_seen;
    assign w_frame_bad  = w_vs_edge && (r_lines != c_LINES_OK);
    assign w_err        = (r_state != c_ST_SEARCH) && (w_period_bad || w_sat_bad || w_frame_bad);
    assign w_good_next  = r_good + c_GOOD_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hs    <= ~c_HS_ON;
            r_hs_d  <= ~c_HS_ON;
            r_vs    <= ~c_VS_ON;
            r_vs_d  <= ~c_VS_ON;
            r_h_pos <= '0;
            r_v_pos <= '0;
        end else begin
            r_hs   <= hsync;
            r_hs_d <= r_hs;
            r_vs   <= vsync;
            r_vs_d <= r_vs;

            if (w_hs_edge)
                r_h_pos <= c_H_LOAD;
            else if (w_h_wrap)
                r_h_pos <= '0;
            else
                r_h_pos <= r_h_pos + 10'd1;

            if (w_vs_edge)
                r_v_pos <= c_V_LOAD;
            else if (w_h_wrap)
                r_v_pos <= (r_v_pos == c_V_LAST) ? 9'd0 : r_v_pos + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_period   <= '0;
            r_sat_seen <= 1'b0;
            r_lines    <= '0;
        end else begin
            if (w_hs_edge)
                r_period <= '0;
            else if (r_period != c_PERIOD_MAX)
                r_period <= r_period + 11'd1;

            if (w_hs_edge)
                r_sat_seen <= 1'b0;
            else if (r_period == c_PERIOD_MAX)
                r_sat_seen <= 1'b1;

            // A coincident hsync edge starts the new frame's first line.
            if (w_vs_edge)
                r_lines <= w_hs_edge ? 10'd1 : 10'd0;
            else if (w_hs_edge && (r_lines != c_LINES_MAX))
                r_lines <= r_lines + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_ST_SEARCH;
            r_good     <= '0;
            r_skip     <= 1'b1;
            r_line_err <= 1'b0;
        end else begin
            r_line_err <= w_err;

            if (r_state == c_ST_SEARCH)
                r_skip <= 1'b1;
            else if (w_hs_edge)
                r_skip <= 1'b0;

            case (r_state)
                c_ST_SEARCH: begin
                    if (w_vs_edge) begin
                        r_state <= c_ST_MEASURE;
                        r_good  <= '0;
                    end
                end
                c_ST_MEASURE: begin
                    if (w_err) begin
                        r_state <= c_ST_SEARCH;
                    end else if (w_vs_edge) begin
                        r_good <= w_good_next;
                        if (w_good_next == c_GOOD_LOCK)
                            r_state <= c_ST_LOCKED;
                    end
                end
                c_ST_LOCKED: begin
                    if (w_err)
                        r_state <= c_ST_SEARCH;
                end
                default: r_state <= c_ST_SEARCH;
            endcase
        end
    end

    assign h_pos       = r_h_pos;
    assign v_pos       = r_v_pos;
    assign locked      = (r_state == c_ST_LOCKED);
    assign de          = locked && (r_h_pos < 10'(H_VISIBLE)) && (r_v_pos < 9'(V_VISIBLE));
    assign frame_start = locked && (r_h_pos == 10'd0) && (r_v_pos == 9'd0);
    assign line_err    = r_line_err;

endmodule
`default_nettype wire
